// File: rtl/rename_freelist.sv
// Physical-register free list for the rename stage.
// A ring of free preg indices with three pointers. Rename takes entries from
// head, commit returns superseded pregs at tail, and retire_head records how
// far allocation has committed so that a flush can move head back to it.
// Pointers carry one extra MSB as a wrap bit, so count = tail - head can tell
// a full ring from an empty one.
module rename_freelist #(
   parameter int FRONTEND_WIDTH      = 2,
   parameter int PHYS_REGS           = 64,
   parameter int PHYS_REGS_ADDR_SIZE = 6,
   parameter int ARCH_REGS           = 32
) (
   input  logic                                                clk,
   input  logic                                                reset,
   input  logic [FRONTEND_WIDTH-1:0]                           alloc_req_i,
   output logic                                                alloc_ready_o,
   output logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0]  freelist_preg_o,
   input  logic [FRONTEND_WIDTH-1:0]                           commit_alloc_v_i,
   input  logic [FRONTEND_WIDTH-1:0]                           commit_free_v_i,
   input  logic [FRONTEND_WIDTH-1:0][PHYS_REGS_ADDR_SIZE-1:0]  commit_free_preg_i,
   input  logic                                                flush_i,
   output logic [PHYS_REGS_ADDR_SIZE:0]                        free_count_o,
   output logic                                                overflow_err_o
);

   localparam int PW = PHYS_REGS_ADDR_SIZE + 1;

   typedef logic [PW-1:0]                  ptr_t;
   typedef logic [PHYS_REGS_ADDR_SIZE-1:0] preg_t;

   // Number of set bits in a slot vector, widened to pointer width.
   function automatic ptr_t popcount_f(input logic [FRONTEND_WIDTH-1:0] v);
      ptr_t c;
      c = '0;
      for (int i = 0; i < FRONTEND_WIDTH; i++) begin
         c = c + ptr_t'(v[i]);
      end
      return c;
   endfunction

   preg_t ring_q [PHYS_REGS];
   preg_t ring_d [PHYS_REGS];
   ptr_t  head_q, head_d;
   ptr_t  retire_head_q, retire_head_d;
   ptr_t  tail_q, tail_d;
   logic  overflow_q, overflow_d;

   ptr_t  count_s;
   ptr_t  alloc_n_s;
   ptr_t  rd_off_s;
   ptr_t  wr_off_s;
   ptr_t  space_s;
   logic  ready_s;

   // Allocation side: all-or-nothing grant and compacted read of the ring.
   always_comb begin
      freelist_preg_o = '0;
      count_s         = tail_q - head_q;
      alloc_n_s       = popcount_f(alloc_req_i);
      ready_s         = (count_s >= alloc_n_s) && !flush_i && !reset;
      rd_off_s        = '0;
      for (int i = 0; i < FRONTEND_WIDTH; i++) begin
         if (alloc_req_i[i]) begin
            // Requesting slots take consecutive entries, skipping idle slots.
            freelist_preg_o[i] = ring_q[preg_t'(head_q + rd_off_s)];
            rd_off_s           = rd_off_s + ptr_t'(1'b1);
         end else begin
            freelist_preg_o[i] = '0;
         end
      end
   end

   // Next-state: frees at tail, retire tracking, head advance or flush rewind.
   always_comb begin
      ring_d     = ring_q;
      overflow_d = overflow_q;
      space_s    = ptr_t'(PHYS_REGS) - count_s;
      wr_off_s   = '0;
      for (int i = 0; i < FRONTEND_WIDTH; i++) begin
         if (commit_free_v_i[i]) begin
            if (wr_off_s < space_s) begin
               ring_d[preg_t'(tail_q + wr_off_s)] = commit_free_preg_i[i];
               wr_off_s = wr_off_s + ptr_t'(1'b1);
            end else begin
               // Ring already full: drop the write and remember it happened.
               overflow_d = 1'b1;
            end
         end else begin
            wr_off_s = wr_off_s;
         end
      end
      tail_d        = tail_q + wr_off_s;
      retire_head_d = retire_head_q + popcount_f(commit_alloc_v_i);
      if (flush_i) begin
         // Speculative allocations return to the pool; include this cycle's retires.
         head_d = retire_head_d;
      end else if (ready_s) begin
         head_d = head_q + alloc_n_s;
      end else begin
         head_d = head_q;
      end
   end

   // State registers with the reset image: pregs ARCH_REGS.. are free.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < PHYS_REGS; k++) begin
            ring_q[k] <= (k < PHYS_REGS - ARCH_REGS) ? preg_t'(k + ARCH_REGS) : '0;
         end
         head_q        <= '0;
         retire_head_q <= '0;
         tail_q        <= ptr_t'(PHYS_REGS - ARCH_REGS);
         overflow_q    <= 1'b0;
      end else begin
         ring_q        <= ring_d;
         head_q        <= head_d;
         retire_head_q <= retire_head_d;
         tail_q        <= tail_d;
         overflow_q    <= overflow_d;
      end
   end

   assign alloc_ready_o  = ready_s;
   assign free_count_o   = count_s;
   assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_rename_freelist.sv
// Bench for rename_freelist: a queue-based model of the free pool plus
// directed sequences with hand-computed expectations.
module tb_rename_freelist;

   localparam int FW = 2;
   localparam int PR = 64;
   localparam int AS = 6;
   localparam int AR = 32;

   logic                   clk;
   logic                   reset;
   logic [FW-1:0]          alloc_req;
   logic                   alloc_ready_o;
   logic [FW-1:0][AS-1:0]  freelist_preg_o;
   logic [FW-1:0]          commit_alloc_v;
   logic [FW-1:0]          commit_free_v;
   logic [FW-1:0][AS-1:0]  free_preg;
   logic                   flush;
   logic [AS:0]            free_count_o;
   logic                   overflow_err_o;

   int errors = 0;
   int checks = 0;

   // Model: fq = pregs free for allocation, in allocation order;
   // spec = pregs handed out but not yet retired, oldest first.
   int fq[$];
   int spec[$];
   bit model_valid = 1'b0;

   int   cmp_n;
   int   cmp_k;
   logic cmp_rdy;

   rename_freelist #(
      .FRONTEND_WIDTH(FW),
      .PHYS_REGS(PR),
      .PHYS_REGS_ADDR_SIZE(AS),
      .ARCH_REGS(AR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .alloc_req_i(alloc_req),
      .alloc_ready_o(alloc_ready_o),
      .freelist_preg_o(freelist_preg_o),
      .commit_alloc_v_i(commit_alloc_v),
      .commit_free_v_i(commit_free_v),
      .commit_free_preg_i(free_preg),
      .flush_i(flush),
      .free_count_o(free_count_o),
      .overflow_err_o(overflow_err_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply the effect of one clock edge to the model, using the inputs held for that edge.
   task automatic model_update();
      int n;
      int pre;
      bit rdy;
      if (reset) begin
         fq.delete();
         spec.delete();
         for (int k = 0; k < PR - AR; k++) fq.push_back(k + AR);
         model_valid = 1'b1;
         return;
      end
      if (!model_valid) return;
      n   = $countones(alloc_req);
      pre = fq.size();
      rdy = (pre >= n) && !flush;
      if (rdy) begin
         for (int i = 0; i < n; i++) spec.push_back(fq.pop_front());
      end
      for (int i = 0; i < $countones(commit_alloc_v); i++) begin
         if (spec.size() > 0) void'(spec.pop_front());
      end
      for (int i = 0; i < FW; i++) begin
         if (commit_free_v[i] && (pre < PR)) begin
            fq.push_back(int'(free_preg[i]));
            pre++;
         end
      end
      if (flush) begin
         fq = {spec, fq};
         spec.delete();
      end
   endtask

   // Wait for an edge (updating the model for it), then present new inputs.
   task automatic drive(input logic [FW-1:0] req, input logic [FW-1:0] cav,
                        input logic [FW-1:0] cfv, input int f0, input int f1,
                        input logic fl, input logic rs);
      @(posedge clk);
      model_update();
      #2;
      alloc_req      = req;
      commit_alloc_v = cav;
      commit_free_v  = cfv;
      free_preg[0]   = AS'(f0);
      free_preg[1]   = AS'(f1);
      flush          = fl;
      reset          = rs;
      #1;
   endtask

   // Compare process: DUT outputs against the model every cycle.
   always @(negedge clk) begin
      if (model_valid) begin
         cmp_n   = $countones(alloc_req);
         cmp_rdy = (fq.size() >= cmp_n) && !flush && !reset;
         chk("model_ready", 32'(alloc_ready_o), 32'(cmp_rdy));
         chk("model_free_count", 32'(free_count_o), fq.size());
         chk("model_overflow", 32'(overflow_err_o), 32'd0);
         cmp_k = 0;
         for (int i = 0; i < FW; i++) begin
            if (alloc_req[i]) begin
               if (cmp_rdy) chk("model_preg", 32'(freelist_preg_o[i]), fq[cmp_k]);
               cmp_k++;
            end else begin
               chk("model_preg_idle", 32'(freelist_preg_o[i]), 32'd0);
            end
         end
      end
   end

   initial begin
      reset          = 1'b1;
      alloc_req      = '0;
      commit_alloc_v = '0;
      commit_free_v  = '0;
      free_preg      = '0;
      flush          = 1'b0;

      // Reset image.
      drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("reset_free_count", 32'(free_count_o), 32'd32);
      chk("reset_overflow", 32'(overflow_err_o), 32'd0);
      chk("reset_ready_idle", 32'(alloc_ready_o), 32'd1);

      // Drain the pool two at a time: 32,33 .. 62,63.
      for (int c = 0; c < 16; c++) begin
         drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
         chk("drain_ready", 32'(alloc_ready_o), 32'd1);
         chk("drain_count", 32'(free_count_o), 32'(32 - 2 * c));
         chk("drain_slot0", 32'(freelist_preg_o[0]), 32'(32 + 2 * c));
         chk("drain_slot1", 32'(freelist_preg_o[1]), 32'(33 + 2 * c));
      end
      drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("empty_ready", 32'(alloc_ready_o), 32'd0);
      chk("empty_count", 32'(free_count_o), 32'd0);
      drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("empty_hold", 32'(free_count_o), 32'd0);

      // One free entry: a two-slot request stalls, a one-slot request gets it.
      drive(2'b00, 2'b00, 2'b01, 5, 0, 1'b0, 1'b0);
      drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("one_count", 32'(free_count_o), 32'd1);
      chk("one_stall", 32'(alloc_ready_o), 32'd0);
      drive(2'b10, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("one_not_consumed", 32'(free_count_o), 32'd1);
      chk("one_ready", 32'(alloc_ready_o), 32'd1);
      chk("one_slot1", 32'(freelist_preg_o[1]), 32'd5);
      chk("one_slot0_zero", 32'(freelist_preg_o[0]), 32'd0);
      drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("one_taken", 32'(free_count_o), 32'd0);

      // Flush rewind: allocate 32..37, retire 32,33, flush, expect 34 next.
      drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
      drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("rst2_count", 32'(free_count_o), 32'd32);
      for (int c = 0; c < 3; c++) drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      drive(2'b00, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("pre_flush_count", 32'(free_count_o), 32'd26);
      drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b1, 1'b0);
      chk("flush_ready", 32'(alloc_ready_o), 32'd0);
      drive(2'b01, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("post_flush_count", 32'(free_count_o), 32'd30);
      chk("post_flush_slot0", 32'(freelist_preg_o[0]), 32'd34);

      // Same-cycle alloc and free of 5,7: no bypass, count unchanged.
      drive(2'b11, 2'b00, 2'b11, 5, 7, 1'b0, 1'b0);
      chk("af_count", 32'(free_count_o), 32'd29);
      chk("af_slot0", 32'(freelist_preg_o[0]), 32'd35);
      chk("af_slot1", 32'(freelist_preg_o[1]), 32'd36);
      drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("af_count_after", 32'(free_count_o), 32'd29);
      for (int c = 0; c < 13; c++) drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      drive(2'b11, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("wrap_slot0", 32'(freelist_preg_o[0]), 32'd63);
      chk("wrap_slot1", 32'(freelist_preg_o[1]), 32'd5);
      drive(2'b01, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("wrap_slot0_7", 32'(freelist_preg_o[0]), 32'd7);
      drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("wrap_empty", 32'(free_count_o), 32'd0);

      // Reset overrides everything active in the same cycle.
      drive(2'b11, 2'b11, 2'b11, 9, 10, 1'b1, 1'b1);
      chk("rst_busy_ready", 32'(alloc_ready_o), 32'd0);
      drive(2'b01, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      chk("rst_busy_count", 32'(free_count_o), 32'd32);
      chk("rst_busy_slot0", 32'(freelist_preg_o[0]), 32'd32);
      chk("rst_busy_overflow", 32'(overflow_err_o), 32'd0);
      drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      drive(2'b00, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
